// File: rtl/clk_freq_monitor.sv
// rtl/clk_freq_monitor.sv - multi-channel gated toggle counter with range checks and sticky faults
// Toggles are synchronised, edge-counted over a gate window, captured, and range-checked per channel.
module clk_freq_monitor #(
  parameter int NUM_CH      = 4,
  parameter int GATE_CYCLES = 100000,
  parameter int CNT_W       = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      CLK_100MHZ,
  input  logic                      RESET_N,
  input  logic                      ENABLE,
  input  logic [NUM_CH-1:0]         TOGGLE_IN,
  input  logic [NUM_CH*CNT_W-1:0]   MIN_CNT,
  input  logic [NUM_CH*CNT_W-1:0]   MAX_CNT,
  input  logic                      FAULT_CLR,
  output logic [NUM_CH*CNT_W-1:0]   COUNT_OUT,
  output logic                      MEAS_VALID,
  output logic [NUM_CH-1:0]         IN_RANGE,
  output logic [NUM_CH-1:0]         FAULT,
  output logic                      ALL_LOCKED
);
  localparam int                GATE_W    = $clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_SAT   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_MEASURE} state_t;

  state_t                             state_q;
  logic [GATE_W-1:0]                  gate_q;
  logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q;
  logic [NUM_CH-1:0]                  prev_q;
  logic [NUM_CH-1:0][CNT_W-1:0]       cnt_q;
  logic [NUM_CH-1:0][CNT_W-1:0]       count_q;
  logic [NUM_CH-1:0]                  in_range_q;
  logic [NUM_CH-1:0]                  fault_q;
  logic                               meas_valid_q;
  logic                               all_locked_q;

  logic [NUM_CH-1:0]                  sync_out;
  logic [NUM_CH-1:0]                  toggle_edge;
  logic [NUM_CH-1:0][CNT_W-1:0]       cnt_d;
  logic [NUM_CH-1:0]                  in_range_d;

  assign sync_out    = sync_q[SYNC_STAGES-1];
  assign toggle_edge = sync_out ^ prev_q;

  // cnt_d already includes this cycle's edge, so the terminal cycle's transition lands in the closing window
  always_comb begin
    cnt_d      = cnt_q;
    in_range_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (toggle_edge[i] && (cnt_q[i] != CNT_SAT)) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
      in_range_d[i] = (cnt_d[i] >= MIN_CNT[i*CNT_W +: CNT_W]) &&
                      (cnt_d[i] <= MAX_CNT[i*CNT_W +: CNT_W]);
    end
  end

  always_ff @(posedge CLK_100MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= S_IDLE;
      gate_q       <= '0;
      sync_q       <= '0;
      prev_q       <= '0;
      cnt_q        <= '0;
      count_q      <= '0;
      in_range_q   <= '0;
      fault_q      <= '0;
      meas_valid_q <= 1'b0;
      all_locked_q <= 1'b0;
    end else begin
      sync_q       <= {sync_q[SYNC_STAGES-2:0], TOGGLE_IN};
      prev_q       <= sync_out;
      meas_valid_q <= 1'b0;
      if (FAULT_CLR) begin
        fault_q <= '0;
      end
      if (!ENABLE) begin
        state_q      <= S_IDLE;
        gate_q       <= '0;
        cnt_q        <= '0;
        all_locked_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            state_q <= S_WARMUP;
            gate_q  <= '0;
            cnt_q   <= '0;
          end
          default: begin
            if (gate_q == GATE_LAST) begin
              gate_q  <= '0;
              cnt_q   <= '0;
              state_q <= S_MEASURE;
              if (state_q == S_MEASURE) begin
                count_q      <= cnt_d;
                in_range_q   <= in_range_d;
                fault_q      <= (FAULT_CLR ? '0 : fault_q) | ~in_range_d;
                meas_valid_q <= 1'b1;
                all_locked_q <= &in_range_d;
              end
            end else begin
              gate_q <= gate_q + 1'b1;
              cnt_q  <= cnt_d;
            end
          end
        endcase
      end
    end
  end

  assign COUNT_OUT  = count_q;
  assign MEAS_VALID = meas_valid_q;
  assign IN_RANGE   = in_range_q;
  assign FAULT      = fault_q;
  assign ALL_LOCKED = all_locked_q;

endmodule

// File: tb/tb_clk_freq_monitor.sv
// tb/tb_clk_freq_monitor.sv - scoreboard bench for clk_freq_monitor
// Toggle phases are tied to the enable edge so every window count is exact.
`timescale 1ns/1ps
module tb_clk_freq_monitor;
  localparam int G = 1000;

  logic        clk = 1'b0;
  logic        rst_n, enable, fault_clr;
  logic [1:0]  tog;
  logic [23:0] min_cnt, max_cnt, count_out;
  logic        meas_valid, all_locked;
  logic [1:0]  in_range, fault;

  logic        s_tog, s_clr;
  logic [5:0]  s_min, s_max, s_count;
  logic        s_mv, s_in_range, s_fault, s_lock;

  clk_freq_monitor #(.NUM_CH(2), .GATE_CYCLES(G), .CNT_W(12), .SYNC_STAGES(2)) dut (
    .CLK_100MHZ(clk), .RESET_N(rst_n), .ENABLE(enable), .TOGGLE_IN(tog),
    .MIN_CNT(min_cnt), .MAX_CNT(max_cnt), .FAULT_CLR(fault_clr),
    .COUNT_OUT(count_out), .MEAS_VALID(meas_valid), .IN_RANGE(in_range),
    .FAULT(fault), .ALL_LOCKED(all_locked)
  );

  clk_freq_monitor #(.NUM_CH(1), .GATE_CYCLES(G), .CNT_W(6), .SYNC_STAGES(2)) dut_sat (
    .CLK_100MHZ(clk), .RESET_N(rst_n), .ENABLE(enable), .TOGGLE_IN(s_tog),
    .MIN_CNT(s_min), .MAX_CNT(s_max), .FAULT_CLR(s_clr),
    .COUNT_OUT(s_count), .MEAS_VALID(s_mv), .IN_RANGE(s_in_range),
    .FAULT(s_fault), .ALL_LOCKED(s_lock)
  );

  typedef struct {
    int         t;
    int         c0;
    int         c1;
    logic [1:0] rng;
    logic [1:0] flt;
    logic       lock;
    int         sc;
  } exp_t;

  exp_t q[$];
  exp_t sq[$];
  exp_t em, es;
  int   n_chk = 0, n_fail = 0, cyc = 0, en = 0, mv_seen = 0;
  bit   run1 = 1'b1;

  task automatic chk(input string name, input longint act, input longint req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d at cycle %0d", name, act, req, cyc);
    end
  endtask

  task automatic push(input int t, input int c0, input int c1, input logic [1:0] rng,
                      input logic [1:0] flt, input logic lock, input int sc);
    exp_t e;
    e.t = en + t; e.c0 = c0; e.c1 = c1; e.rng = rng; e.flt = flt; e.lock = lock; e.sc = sc;
    q.push_back(e);
    sq.push_back(e);
  endtask

  task automatic wait_t(input int n);
    while (cyc - en < n) @(negedge clk);
  endtask

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ch0 flips every 4, ch1 every 10 at t%10==7 (last one lands in the terminal slot), sat ch every 2
  initial begin
    tog   = 2'b00;
    s_tog = 1'b0;
    forever begin
      @(negedge clk);
      if ((cyc - en) % 4 == 0) tog[0] = ~tog[0];
      if (run1 && ((cyc - en - 7) % 10 == 0)) tog[1] = ~tog[1];
      if ((cyc - en) % 2 == 0) s_tog = ~s_tog;
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1 && meas_valid === 1'b1) begin
      mv_seen++;
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_meas_valid: actual 1 required 0 at cycle %0d", cyc);
      end else begin
        em = q.pop_front();
        chk("mv_cycle", cyc, em.t);
        chk("count_ch0", count_out[11:0], em.c0);
        chk("count_ch1", count_out[23:12], em.c1);
        chk("in_range", in_range, em.rng);
        chk("fault", fault, em.flt);
        chk("all_locked", all_locked, em.lock);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1 && s_mv === 1'b1) begin
      if (sq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_sat_meas_valid: actual 1 required 0 at cycle %0d", cyc);
      end else begin
        es = sq.pop_front();
        chk("sat_mv_cycle", cyc, es.t);
        chk("sat_count", s_count, es.sc);
        chk("sat_in_range", s_in_range, 1);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b1;
    enable    = 1'b0;
    fault_clr = 1'b0;
    s_clr     = 1'b0;
    min_cnt   = {12'd99, 12'd249};
    max_cnt   = {12'd101, 12'd251};
    s_min     = 6'd60;
    s_max     = 6'd63;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_count_out", count_out, 0);
    chk("rst_meas_valid", meas_valid, 0);
    chk("rst_in_range", in_range, 0);
    chk("rst_fault", fault, 0);
    chk("rst_all_locked", all_locked, 0);
    chk("rst_sat_count", s_count, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    enable = 1'b1;
    en     = cyc + 1;
    push(2000, 250, 100, 2'b11, 2'b00, 1'b1, 63);
    push(3000, 250, 100, 2'b11, 2'b00, 1'b1, 63);
    push(4000, 250,   0, 2'b01, 2'b10, 1'b0, 63);
    push(5000, 250, 100, 2'b11, 2'b10, 1'b1, 63);
    push(6000, 250, 100, 2'b11, 2'b00, 1'b1, 63);
    push(7000, 250,   0, 2'b01, 2'b10, 1'b0, 63);
    push(8000, 250, 100, 2'b11, 2'b10, 1'b1, 63);

    wait_t(500);
    chk("warmup_all_locked", all_locked, 0);
    wait_t(3000); run1 = 1'b0;
    wait_t(4000); run1 = 1'b1;
    wait_t(5500); fault_clr = 1'b1;
    wait_t(5501); fault_clr = 1'b0;
    wait_t(5502);
    chk("fault_after_clr", fault, 0);
    chk("in_range_hold_after_clr", in_range, 2'b11);
    wait_t(6000); run1 = 1'b0;
    wait_t(6999); fault_clr = 1'b1;
    wait_t(7000); fault_clr = 1'b0; run1 = 1'b1;

    wait_t(8499); enable = 1'b0;
    wait_t(8600);
    chk("idle_all_locked", all_locked, 0);
    chk("idle_count_hold", count_out, {12'd100, 12'd250});
    chk("idle_in_range_hold", in_range, 2'b11);
    chk("idle_fault_hold", fault, 2'b10);
    wait_t(9300);

    enable = 1'b1;
    en     = cyc + 1;
    push(2000, 250, 100, 2'b11, 2'b10, 1'b1, 63);
    wait_t(500);
    chk("rewarmup_all_locked", all_locked, 0);
    chk("rewarmup_count_hold", count_out, {12'd100, 12'd250});
    wait_t(2500);
    rst_n = 1'b0;
    #1;
    chk("midrst_count_out", count_out, 0);
    chk("midrst_meas_valid", meas_valid, 0);
    chk("midrst_in_range", in_range, 0);
    chk("midrst_fault", fault, 0);
    chk("midrst_all_locked", all_locked, 0);
    chk("midrst_sat_count", s_count, 0);
    chk("pending_main", q.size(), 0);
    chk("pending_sat", sq.size(), 0);
    chk("meas_valid_pulses", mv_seen, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
